// File: rtl/ras_return_checker.sv
// ras_return_checker: in-order queue of predicted JALR return addresses.
// Compares each resolved JALR target against the oldest prediction and
// signals a mispredict (plus a stack checkpoint restore) on disagreement.
module ras_return_checker #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq,
  input  logic [XLEN-1:0]          enq_address,
  input  logic                     enq_address_valid,
  input  logic                     resolve,
  input  logic [XLEN-1:0]          resolved_target,
  input  logic                     flush,
  output logic                     mispredict,
  output logic [XLEN-1:0]          correct_target,
  output logic                     restore_checkpoint,
  output logic                     overflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            empty_c;
  logic            full_c;
  logic            head_valid_c;
  logic [XLEN-1:0] head_addr_c;
  logic            do_deq_c;
  logic            mis_c;
  logic            enq_ok_c;
  logic            ovf_c;

  // Decide what this edge does: dequeue, mispredict, accept or drop enqueue.
  always_comb begin
    empty_c      = (count_q == '0);
    full_c       = (count_q == CW'(DEPTH));
    head_valid_c = vld_q[rd_ptr_q];
    head_addr_c  = addr_q[rd_ptr_q];
    do_deq_c     = resolve && !empty_c && !flush;
    mis_c        = do_deq_c && (!head_valid_c || (head_addr_c != resolved_target));
    // A same-cycle dequeue frees the slot, so a full queue can still accept.
    enq_ok_c     = enq && !flush && !mis_c && (!full_c || do_deq_c);
    ovf_c        = enq && !flush && !mis_c && full_c && !do_deq_c;
  end

  // Queue storage, pointers, count and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
      end
      vld_q              <= '0;
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      mispredict         <= 1'b0;
      restore_checkpoint <= 1'b0;
      correct_target     <= '0;
      overflow           <= 1'b0;
    end else begin
      mispredict         <= mis_c;
      restore_checkpoint <= mis_c;
      correct_target     <= mis_c ? resolved_target : '0;
      overflow           <= ovf_c;
      if (flush || mis_c) begin
        // Everything still queued is wrong-path.
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (enq_ok_c) begin
          addr_q[wr_ptr_q] <= enq_address;
          vld_q[wr_ptr_q]  <= enq_address_valid;
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (do_deq_c) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_q + CW'(enq_ok_c) - CW'(do_deq_c);
      end
    end
  end

  // Status flags reflect the registered occupancy.
  assign count = count_q;
  assign empty = empty_c;
  assign full  = full_c;

endmodule
